act_pack_vp: RTL and testbench

//  Packs 2/4/8-bit quantized activations into OUT_WIDTH-bit words for the activation buffer.

---
 rtl/bitblade_pkg.sv | 24 ++
 rtl/act_pack_fifo.sv | 60 ++++++
 rtl/act_pack_vp.sv | 133 +++++++++++++
 tb/tb_act_pack_vp.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/bitblade_pkg.sv
// rtl/bitblade_pkg.sv - precision encodings and element-geometry helpers for the activation packer
package bitblade_pkg;

    typedef enum logic [1:0] {
        PREC_2B  = 2'd0,
        PREC_4B  = 2'd1,
        PREC_8B  = 2'd2,
        PREC_RSV = 2'd3
    } prec_e;

    // Reserved encoding behaves as 8-bit.
    function automatic int prec_bits(input logic [1:0] prec);
        case (prec)
            PREC_2B: return 2;
            PREC_4B: return 4;
            default: return 8;
        endcase
    endfunction

    function automatic int elems_per_word(input logic [1:0] prec, input int width);
        return width / prec_bits(prec);
    endfunction

endpackage

// File: rtl/act_pack_fifo.sv
// rtl/act_pack_fifo.sv - synchronous word FIFO with registered head entry and occupancy count
module act_pack_fifo
    import bitblade_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_vld,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && (count != '0);
    // When full, a simultaneous pop frees the slot the write lands in.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign out_vld  = (count != '0);
    assign out_data = out_vld ? mem[rd_ptr] : '0;

endmodule

// File: rtl/act_pack_vp.sv
// rtl/act_pack_vp.sv - packs 2/4/8-bit activations into words; ACT_PACK_WCNT_EN adds word_cnt_o
module act_pack_vp
    import bitblade_pkg::*;
#(
    parameter int OUT_WIDTH  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           data_i,
    input  logic                 vld_i,
    input  logic [1:0]           fmap_precision,
    input  logic                 flush_i,
    output logic                 in_rdy_o,
    output logic [OUT_WIDTH-1:0] out_data_o,
    output logic                 out_vld_o,
    output logic                 out_last_o,
    input  logic                 out_rdy_i,
    output logic                 flush_done_o,
    output logic                 overflow_o
`ifdef ACT_PACK_WCNT_EN
    ,
    output logic [15:0]          word_cnt_o
`endif
);
    localparam int CW  = $clog2(OUT_WIDTH / 2);
    localparam int SW  = $clog2(OUT_WIDTH);
    localparam int CTW = $clog2(FIFO_DEPTH) + 1;
    localparam int N2  = elems_per_word(PREC_2B, OUT_WIDTH);
    localparam int N4  = elems_per_word(PREC_4B, OUT_WIDTH);
    localparam int N8  = elems_per_word(PREC_8B, OUT_WIDTH);

    logic [OUT_WIDTH-1:0] acc;
    logic [CW-1:0]        cnt;
    logic [1:0]           prec_q;
    logic [1:0]           eff_prec;
    logic [OUT_WIDTH-1:0] slot;
    logic [SW-1:0]        shamt;
    logic [CW-1:0]        last_idx;
    logic [OUT_WIDTH-1:0] new_acc;
    logic                 complete;
    logic                 push;
    logic                 pop;
    logic                 fifo_full;
    logic [CTW-1:0]       fifo_count;
    logic [OUT_WIDTH:0]   head;

    // A new word takes the live precision; later elements reuse the latched one.
    always_comb begin
        eff_prec = (cnt == '0) ? fmap_precision : prec_q;
        slot     = '0;
        shamt    = '0;
        last_idx = '0;
        case (eff_prec)
            PREC_2B: begin
                slot[1:0] = data_i[1:0];
                shamt     = SW'({cnt, 1'b0});
                last_idx  = CW'(N2 - 1);
            end
            PREC_4B: begin
                slot[3:0] = data_i[3:0];
                shamt     = SW'({cnt, 2'b00});
                last_idx  = CW'(N4 - 1);
            end
            default: begin
                slot[7:0] = data_i;
                shamt     = SW'({cnt, 3'b000});
                last_idx  = CW'(N8 - 1);
            end
        endcase
        new_acc  = vld_i ? (acc | (slot << shamt)) : acc;
        complete = vld_i && (cnt == last_idx);
        push     = complete || (flush_i && (vld_i || (cnt != '0)));
    end

    assign pop       = out_vld_o && out_rdy_i;
    assign fifo_full = (fifo_count == CTW'(FIFO_DEPTH));

    act_pack_fifo #(
        .WIDTH (OUT_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({flush_i, new_acc}),
        .pop       (pop),
        .out_data  (head),
        .out_vld   (out_vld_o),
        .count     (fifo_count)
    );

    assign out_data_o = head[OUT_WIDTH-1:0];
    assign out_last_o = head[OUT_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            acc          <= '0;
            cnt          <= '0;
            prec_q       <= PREC_2B;
            flush_done_o <= 1'b0;
            overflow_o   <= 1'b0;
            in_rdy_o     <= 1'b1;
        end else begin
            if (vld_i && (cnt == '0)) begin
                prec_q <= fmap_precision;
            end
            if (push) begin
                acc <= '0;
                cnt <= '0;
            end else if (vld_i) begin
                acc <= new_acc;
                cnt <= cnt + 1'b1;
            end
            flush_done_o <= flush_i;
            if (push && fifo_full && !pop) begin
                overflow_o <= 1'b1;
            end
            in_rdy_o <= (CTW'(FIFO_DEPTH) - fifo_count) >= CTW'(2);
        end
    end

`ifdef ACT_PACK_WCNT_EN
    always_ff @(posedge clk) begin
        if (rst || flush_done_o) begin
            word_cnt_o <= '0;
        end else if (pop) begin
            word_cnt_o <= word_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_act_pack_vp.sv
// tb/tb_act_pack_vp.sv - directed bench with queue-based reference model for act_pack_vp
`timescale 1ns/1ps
module tb_act_pack_vp;
    localparam int W = 32;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   data;
    logic         vld;
    logic [1:0]   prec;
    logic         flush;
    logic         in_rdy;
    logic [W-1:0] out_data;
    logic         out_vld;
    logic         out_last;
    logic         out_rdy;
    logic         flush_done;
    logic         overflow;
`ifdef ACT_PACK_WCNT_EN
    logic [15:0]  word_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    act_pack_vp #(.OUT_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk            (clk),
        .rst            (rst),
        .data_i         (data),
        .vld_i          (vld),
        .fmap_precision (prec),
        .flush_i        (flush),
        .in_rdy_o       (in_rdy),
        .out_data_o     (out_data),
        .out_vld_o      (out_vld),
        .out_last_o     (out_last),
        .out_rdy_i      (out_rdy),
        .flush_done_o   (flush_done),
        .overflow_o     (overflow)
`ifdef ACT_PACK_WCNT_EN
        ,
        .word_cnt_o     (word_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: element list per word, word queue for the FIFO.
    logic [1:0]  m_prec;
    int          m_vals[$];
    logic [32:0] m_q[$];
    bit          m_ovf, m_fd, m_inrdy, m_init;
    int unsigned m_wcnt;
    int          sz0, nb, ne;
    bit          m_pop, m_push;
    logic [32:0] m_w;

    function automatic int bits_of(input logic [1:0] p);
        if (p == 2'd0) return 2;
        if (p == 2'd1) return 4;
        return 8;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_vals.delete();
            m_q.delete();
            m_ovf = 0; m_fd = 0; m_inrdy = 1; m_init = 1; m_wcnt = 0; m_prec = 2'd0;
        end else if (m_init) begin
            sz0    = m_q.size();
            m_pop  = (sz0 > 0) && out_rdy;
            m_push = 0;
            if (vld) begin
                if (m_vals.size() == 0) m_prec = prec;
                m_vals.push_back(int'(data));
            end
            nb = bits_of(m_prec);
            ne = W / nb;
            if (m_vals.size() == ne || (flush && m_vals.size() > 0)) begin
                m_w = '0;
                for (int i = 0; i < m_vals.size(); i++)
                    m_w[31:0] = m_w[31:0] | ((32'(m_vals[i]) & ((32'd1 << nb) - 32'd1)) << (i * nb));
                m_w[32] = flush;
                m_push = 1;
                m_vals.delete();
            end
            if (m_fd) m_wcnt = 0;
            else if (m_pop) m_wcnt = (m_wcnt + 1) & 32'hFFFF;
            m_fd    = flush;
            m_inrdy = (D - sz0) >= 2;
            if (m_pop) void'(m_q.pop_front());
            if (m_push) begin
                if (sz0 == D && !m_pop) m_ovf = 1;
                else m_q.push_back(m_w);
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("out_vld", {32'd0, out_vld}, {32'd0, m_q.size() > 0});
            chk("out_data", {1'b0, out_data}, (m_q.size() > 0) ? {1'b0, m_q[0][31:0]} : 33'd0);
            chk("out_last", {32'd0, out_last}, (m_q.size() > 0) ? {32'd0, m_q[0][32]} : 33'd0);
            chk("in_rdy", {32'd0, in_rdy}, {32'd0, m_inrdy});
            chk("flush_done", {32'd0, flush_done}, {32'd0, m_fd});
            chk("overflow", {32'd0, overflow}, {32'd0, m_ovf});
`ifdef ACT_PACK_WCNT_EN
            chk("word_cnt", {17'd0, word_cnt}, {17'd0, m_wcnt[15:0]});
`endif
        end
    end

    task automatic cyc(input logic v, input logic [7:0] d, input logic [1:0] p, input logic f);
        vld = v; data = d; prec = p; flush = f;
        @(posedge clk);
        #1;
        vld = 0; flush = 0;
    endtask

    logic [31:0] bp_words [4];

    initial begin
        bp_words[0] = 32'h04030201;
        bp_words[1] = 32'h14131211;
        bp_words[2] = 32'h24232221;
        bp_words[3] = 32'h34333231;
        rst = 1; vld = 0; data = 0; prec = 0; flush = 0; out_rdy = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld", {32'd0, out_vld}, 33'd0);
        chk("rst_data", {1'b0, out_data}, 33'd0);
        chk("rst_in_rdy", {32'd0, in_rdy}, 33'd1);
        chk("rst_ovf", {32'd0, overflow}, 33'd0);
        rst = 0;

        for (int i = 1; i <= 4; i++) cyc(1, 8'(i), 2'd2, 0);
        chk("b8_word", {out_last, out_data}, {1'b0, 32'h04030201});
        cyc(0, 0, 2'd2, 0);

        for (int i = 0; i < 16; i++) cyc(1, 8'h01, 2'd0, 0);
        chk("b2_ones", {out_last, out_data}, {1'b0, 32'h55555555});
        for (int i = 0; i < 16; i++) cyc(1, 8'hFF, 2'd0, 0);
        chk("b2_neg", {out_last, out_data}, {1'b0, 32'hFFFFFFFF});
        cyc(0, 0, 2'd0, 0);

        cyc(1, 8'h07, 2'd1, 0);
        cyc(1, 8'hF9, 2'd1, 0);
        cyc(1, 8'h01, 2'd1, 0);
        cyc(0, 0, 2'd1, 1);
        chk("b4_flush_word", {out_last, out_data}, {1'b1, 32'h00000197});
        chk("b4_flush_done", {32'd0, flush_done}, 33'd1);
        cyc(0, 0, 2'd1, 0);
        chk("flush_done_once", {32'd0, flush_done}, 33'd0);

        cyc(0, 0, 2'd2, 1);
        chk("empty_flush_vld", {32'd0, out_vld}, 33'd0);
        chk("empty_flush_done", {32'd0, flush_done}, 33'd1);
        cyc(0, 0, 2'd2, 0);

        out_rdy = 0;
        for (int k = 0; k < 5; k++)
            for (int i = 1; i <= 4; i++) cyc(1, 8'((k << 4) | i), 2'd2, 0);
        chk("bp_in_rdy", {32'd0, in_rdy}, 33'd0);
        chk("bp_ovf", {32'd0, overflow}, 33'd1);
        chk("bp_head", {1'b0, out_data}, {1'b0, 32'h04030201});
        out_rdy = 1;
        for (int k = 0; k < 4; k++) begin
            chk("bp_drain", {out_vld, out_data}, {1'b1, bp_words[k]});
            cyc(0, 0, 2'd2, 0);
        end
        chk("bp_empty", {32'd0, out_vld}, 33'd0);
        chk("bp_ovf_sticky", {32'd0, overflow}, 33'd1);

        cyc(1, 8'h11, 2'd2, 0);
        cyc(1, 8'h22, 2'd2, 0);
        cyc(1, 8'h33, 2'd0, 0);
        cyc(1, 8'h44, 2'd0, 0);
        chk("prec_switch", {out_last, out_data}, {1'b0, 32'h44332211});
        for (int i = 0; i < 5; i++) cyc(1, 8'h03, (i < 3) ? 2'd0 : 2'd2, 0);
        rst = 1;
        cyc(0, 0, 2'd0, 0);
        rst = 0;
        chk("mid_rst_vld", {32'd0, out_vld}, 33'd0);
        chk("mid_rst_data", {1'b0, out_data}, 33'd0);
        chk("mid_rst_ovf", {32'd0, overflow}, 33'd0);
        chk("mid_rst_in_rdy", {32'd0, in_rdy}, 33'd1);
        for (int i = 0; i < 16; i++) cyc(1, 8'h02, 2'd0, 0);
        chk("post_rst_word", {out_last, out_data}, {1'b0, 32'hAAAAAAAA});
        repeat (3) cyc(0, 0, 2'd0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
